// File: rtl/ex_alu_pkg.sv
`default_nettype none
// ============================================================================
// ex_alu_pkg : shared widths, op-type encodings and result type for ex_alu
// Revision   : 1.0
// ============================================================================
package ex_alu_pkg;

    localparam int TAG_WIDTH   = 4;
    localparam int OP_WIDTH    = 6;
    localparam int DATA_WIDTH  = 32;
    localparam int EX_BUF_SIZE = 2;

    localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_WIDTH-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_WIDTH-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_WIDTH-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_WIDTH-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_WIDTH-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'd11;
    localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'd12;
    localparam logic [OP_WIDTH-1:0] OP_SLTIU = 6'd13;
    localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'd14;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'd15;
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'd16;
    localparam logic [OP_WIDTH-1:0] OP_SLLI  = 6'd17;
    localparam logic [OP_WIDTH-1:0] OP_SRLI  = 6'd18;
    localparam logic [OP_WIDTH-1:0] OP_SRAI  = 6'd19;
    localparam logic [OP_WIDTH-1:0] OP_ADD   = 6'd20;
    localparam logic [OP_WIDTH-1:0] OP_SUB   = 6'd21;
    localparam logic [OP_WIDTH-1:0] OP_SLL   = 6'd22;
    localparam logic [OP_WIDTH-1:0] OP_SLT   = 6'd23;
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = 6'd24;
    localparam logic [OP_WIDTH-1:0] OP_XOR   = 6'd25;
    localparam logic [OP_WIDTH-1:0] OP_OR    = 6'd26;
    localparam logic [OP_WIDTH-1:0] OP_AND   = 6'd27;
    localparam logic [OP_WIDTH-1:0] OP_SRL   = 6'd28;
    localparam logic [OP_WIDTH-1:0] OP_SRA   = 6'd29;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] target;
        logic                  taken;
    } ex_result_t;

endpackage
`default_nettype wire

// File: rtl/ex_alu_if.sv
`default_nettype none
// ============================================================================
// ex_alu_if : issue and CDB broadcast signals between RS, ex_alu and arbiter
// Revision  : 1.0
// ============================================================================
interface ex_alu_if #(
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
);
    logic              ex_idle;
    logic              if_issue_ex;
    logic [TAG_W-1:0]  dest_ex;
    logic [OP_W-1:0]   op_type_to_ex;
    logic [DATA_W-1:0] data_rs1_to_ex;
    logic [DATA_W-1:0] data_rs2_to_ex;
    logic [DATA_W-1:0] imm_to_ex;
    logic [DATA_W-1:0] pc_to_ex;
    logic              cdb_grant;
    logic              ex_cdb_valid;
    logic [TAG_W-1:0]  ex_cdb_tag;
    logic [DATA_W-1:0] ex_cdb_data;
    logic [DATA_W-1:0] ex_cdb_target;
    logic              ex_cdb_taken;

    modport master (
        input  ex_idle, ex_cdb_valid, ex_cdb_tag, ex_cdb_data, ex_cdb_target, ex_cdb_taken,
        output if_issue_ex, dest_ex, op_type_to_ex, data_rs1_to_ex, data_rs2_to_ex,
               imm_to_ex, pc_to_ex, cdb_grant
    );

    modport slave (
        output ex_idle, ex_cdb_valid, ex_cdb_tag, ex_cdb_data, ex_cdb_target, ex_cdb_taken,
        input  if_issue_ex, dest_ex, op_type_to_ex, data_rs1_to_ex, data_rs2_to_ex,
               imm_to_ex, pc_to_ex, cdb_grant
    );
endinterface
`default_nettype wire

// File: rtl/ex_alu_alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational RV32I ALU / branch / jump evaluation
// Revision : 1.0
// ============================================================================
module alu_core
    import ex_alu_pkg::*;
(
    input  wire logic [OP_WIDTH-1:0]   op_i,
    input  wire logic [DATA_WIDTH-1:0] rs1_i,
    input  wire logic [DATA_WIDTH-1:0] rs2_i,
    input  wire logic [DATA_WIDTH-1:0] imm_i,
    input  wire logic [DATA_WIDTH-1:0] pc_i,
    output ex_result_t                 res_o
);

    logic [DATA_WIDTH-1:0] w_pc4;
    logic [DATA_WIDTH-1:0] w_pc_imm;
    logic [4:0]            w_shr;
    logic [4:0]            w_shi;
    logic                  w_cond;

    assign w_pc4    = pc_i + 32'd4;
    assign w_pc_imm = pc_i + imm_i;
    assign w_shr    = rs2_i[4:0];
    assign w_shi    = imm_i[4:0];

    always_comb begin
        w_cond = 1'b0;
        case (op_i)
            OP_BEQ:  w_cond = (rs1_i == rs2_i);
            OP_BNE:  w_cond = (rs1_i != rs2_i);
            OP_BLT:  w_cond = ($signed(rs1_i) <  $signed(rs2_i));
            OP_BGE:  w_cond = ($signed(rs1_i) >= $signed(rs2_i));
            OP_BLTU: w_cond = (rs1_i <  rs2_i);
            OP_BGEU: w_cond = (rs1_i >= rs2_i);
            default: w_cond = 1'b0;
        endcase
    end

    // Unknown ops fall through to the default: zero data, sequential target
    always_comb begin
        res_o.data   = '0;
        res_o.target = w_pc4;
        res_o.taken  = 1'b0;
        case (op_i)
            OP_ADD:   res_o.data = rs1_i + rs2_i;
            OP_SUB:   res_o.data = rs1_i - rs2_i;
            OP_AND:   res_o.data = rs1_i & rs2_i;
            OP_OR:    res_o.data = rs1_i | rs2_i;
            OP_XOR:   res_o.data = rs1_i ^ rs2_i;
            OP_SLT:   res_o.data = {31'd0, $signed(rs1_i) < $signed(rs2_i)};
            OP_SLTU:  res_o.data = {31'd0, rs1_i < rs2_i};
            OP_SLL:   res_o.data = rs1_i << w_shr;
            OP_SRL:   res_o.data = rs1_i >> w_shr;
            OP_SRA:   res_o.data = $unsigned($signed(rs1_i) >>> w_shr);
            OP_ADDI:  res_o.data = rs1_i + imm_i;
            OP_ANDI:  res_o.data = rs1_i & imm_i;
            OP_ORI:   res_o.data = rs1_i | imm_i;
            OP_XORI:  res_o.data = rs1_i ^ imm_i;
            OP_SLTI:  res_o.data = {31'd0, $signed(rs1_i) < $signed(imm_i)};
            OP_SLTIU: res_o.data = {31'd0, rs1_i < imm_i};
            OP_SLLI:  res_o.data = rs1_i << w_shi;
            OP_SRLI:  res_o.data = rs1_i >> w_shi;
            OP_SRAI:  res_o.data = $unsigned($signed(rs1_i) >>> w_shi);
            OP_LUI:   res_o.data = imm_i;
            OP_AUIPC: res_o.data = w_pc_imm;
            OP_JAL: begin
                res_o.data   = w_pc4;
                res_o.target = w_pc_imm;
                res_o.taken  = 1'b1;
            end
            OP_JALR: begin
                res_o.data   = w_pc4;
                res_o.target = (rs1_i + imm_i) & ~32'd1;
                res_o.taken  = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_o.taken  = w_cond;
                res_o.target = w_cond ? w_pc_imm : w_pc4;
            end
            default: res_o.data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
// ex_alu   : integer execution unit with 2-entry CDB result buffer
// Revision : 1.0
// ============================================================================
module ex_alu
    import ex_alu_pkg::*;
#(
    parameter int TAG_W  = TAG_WIDTH,
    parameter int OP_W   = OP_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic rdy,
    input  wire logic clear,
    ex_alu_if.slave   bus
);

    ex_result_t        w_res;
    logic              w_idle;
    logic              w_push;
    logic              w_pop;

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;

    logic [TAG_W-1:0]  tag_q    [EX_BUF_SIZE];
    logic [DATA_W-1:0] data_q   [EX_BUF_SIZE];
    logic [DATA_W-1:0] target_q [EX_BUF_SIZE];
    logic              taken_q  [EX_BUF_SIZE];

    alu_core u_alu_core (
        .op_i  (bus.op_type_to_ex),
        .rs1_i (bus.data_rs1_to_ex),
        .rs2_i (bus.data_rs2_to_ex),
        .imm_i (bus.imm_to_ex),
        .pc_i  (bus.pc_to_ex),
        .res_o (w_res)
    );

    // Idle comes from registered count only, keeping grant off the RS path
    assign w_idle = (count_q != 2'(EX_BUF_SIZE));
    assign w_push = rdy & bus.if_issue_ex & w_idle;
    assign w_pop  = rdy & (count_q != 2'd0) & bus.cdb_grant;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < EX_BUF_SIZE; i++) begin
                tag_q[i]    <= '0;
                data_q[i]   <= '0;
                target_q[i] <= '0;
                taken_q[i]  <= 1'b0;
            end
        end else if (clear) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_push) begin
                tag_q[wr_ptr_q]    <= bus.dest_ex;
                data_q[wr_ptr_q]   <= w_res.data;
                target_q[wr_ptr_q] <= w_res.target;
                taken_q[wr_ptr_q]  <= w_res.taken;
            end
        end
    end

    assign bus.ex_idle       = w_idle;
    assign bus.ex_cdb_valid  = (count_q != 2'd0);
    assign bus.ex_cdb_tag    = tag_q[rd_ptr_q];
    assign bus.ex_cdb_data   = data_q[rd_ptr_q];
    assign bus.ex_cdb_target = target_q[rd_ptr_q];
    assign bus.ex_cdb_taken  = taken_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_ex_alu.sv
`default_nettype none
// ============================================================================
// tb_ex_alu : directed scoreboard bench for ex_alu
// Revision  : 1.0
// ============================================================================
module tb_ex_alu;
    import ex_alu_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [31:0] target;
        logic        taken;
    } exp_t;

    logic clk;
    logic rst;
    logic rdy;
    logic clear;
    int   errors;
    int   checks;
    exp_t sb[$];
    exp_t pend;

    ex_alu_if #(.TAG_W(4), .OP_W(6), .DATA_W(32)) bus ();

    ex_alu #(.TAG_W(4), .OP_W(6), .DATA_W(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_state(input string step);
        chk({step, ".valid"}, 32'(bus.ex_cdb_valid), 32'(sb.size() != 0));
        chk({step, ".idle"},  32'(bus.ex_idle),      32'(sb.size() < 2));
        if (sb.size() != 0) begin
            chk({step, ".tag"},    32'(bus.ex_cdb_tag),   32'(sb[0].tag));
            chk({step, ".data"},   bus.ex_cdb_data,       sb[0].data);
            chk({step, ".target"}, bus.ex_cdb_target,     sb[0].target);
            chk({step, ".taken"},  32'(bus.ex_cdb_taken), 32'(sb[0].taken));
        end
    endtask

    task automatic set_issue(input logic [3:0] tag, input logic [5:0] op,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [31:0] e_data, input logic [31:0] e_target,
                             input logic e_taken);
        bus.if_issue_ex    = 1'b1;
        bus.dest_ex        = tag;
        bus.op_type_to_ex  = op;
        bus.data_rs1_to_ex = rs1;
        bus.data_rs2_to_ex = rs2;
        bus.imm_to_ex      = imm;
        bus.pc_to_ex       = pc;
        pend.tag    = tag;
        pend.data   = e_data;
        pend.target = e_target;
        pend.taken  = e_taken;
    endtask

    // Update the scoreboard for the inputs now applied, then advance one edge
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (rst || clear) begin
            sb.delete();
        end else if (rdy) begin
            do_pop  = bus.cdb_grant && (sb.size() != 0);
            do_push = bus.if_issue_ex && (sb.size() < 2);
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        rdy    = 1'b1;
        clear  = 1'b0;
        bus.cdb_grant = 1'b0;
        set_issue(4'd9, OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 32'd2, 32'h4, 1'b0);

        // reset with issue held high
        tick();
        tick();
        check_state("reset");
        chk("reset.tag",    32'(bus.ex_cdb_tag),   32'd0);
        chk("reset.data",   bus.ex_cdb_data,       32'd0);
        chk("reset.target", bus.ex_cdb_target,     32'd0);
        chk("reset.taken",  32'(bus.ex_cdb_taken), 32'd0);
        rst = 1'b0;
        bus.if_issue_ex = 1'b0;
        tick();
        check_state("idle");

        // streaming with grant high: each cycle pops the head and pushes a new op
        bus.cdb_grant = 1'b1;
        set_issue(4'd3,  OP_SUB,   32'd5,        32'd7,        32'd0,        32'h40,   32'hFFFFFFFE, 32'h44,   1'b0);
        tick(); check_state("sub");
        set_issue(4'd4,  OP_SRAI,  32'h80000000, 32'd0,        32'h21,       32'h44,   32'hC0000000, 32'h48,   1'b0);
        tick(); check_state("srai");
        set_issue(4'd5,  OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        32'h120,  1'b1);
        tick(); check_state("blt");
        set_issue(4'd6,  OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        32'h104,  1'b0);
        tick(); check_state("bltu");
        set_issue(4'd7,  OP_JALR,  32'h203,      32'd0,        32'd4,        32'h500,  32'h504,      32'h206,  1'b1);
        tick(); check_state("jalr");
        set_issue(4'd8,  OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'h600,  32'h12345000, 32'h604,  1'b0);
        tick(); check_state("lui");
        set_issue(4'd9,  OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     32'h1004, 1'b0);
        tick(); check_state("auipc");
        set_issue(4'd10, OP_JAL,   32'd0,        32'd0,        32'hFFFFFFF8, 32'h300,  32'h304,      32'h2F8,  1'b1);
        tick(); check_state("jal");
        set_issue(4'd11, OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd0,        32'h20,   32'd1,        32'h24,   1'b0);
        tick(); check_state("slt");
        set_issue(4'd12, OP_SLL,   32'd1,        32'h23,       32'd0,        32'h30,   32'd8,        32'h34,   1'b0);
        tick(); check_state("sll");
        set_issue(4'd13, OP_BGE,   32'd5,        32'd5,        32'h10,       32'h80,   32'd0,        32'h90,   1'b1);
        tick(); check_state("bge");
        set_issue(4'd14, 6'h3F,    32'd3,        32'd4,        32'd0,        32'h90,   32'd0,        32'h94,   1'b0);
        tick(); check_state("unknown");
        set_issue(4'd15, OP_SRL,   32'h80000000, 32'h1F,       32'd0,        32'hA0,   32'd1,        32'hA4,   1'b0);
        tick(); check_state("srl");
        bus.if_issue_ex = 1'b0;
        tick(); check_state("drain");

        // back-pressure: grant low, third issue must be dropped
        bus.cdb_grant = 1'b0;
        set_issue(4'd1, OP_ADD, 32'd1,     32'd2,     32'd0, 32'h10, 32'd3,     32'h14, 1'b0);
        tick(); check_state("bp1");
        set_issue(4'd2, OP_XOR, 32'hF0F0,  32'hFF00,  32'd0, 32'h14, 32'h0FF0,  32'h18, 1'b0);
        tick(); check_state("bp2");
        set_issue(4'd3, OP_OR,  32'h1,     32'h2,     32'd0, 32'h18, 32'h3,     32'h1C, 1'b0);
        tick(); check_state("bp3");
        chk("bp3.full_idle", 32'(bus.ex_idle), 32'd0);
        bus.if_issue_ex = 1'b0;
        bus.cdb_grant   = 1'b1;
        tick(); check_state("bp_pop1");
        chk("bp_pop1.tag2", 32'(bus.ex_cdb_tag), 32'd2);
        tick(); check_state("bp_pop2");

        // clear while stalled, with a simultaneous issue that must be discarded
        bus.cdb_grant = 1'b0;
        set_issue(4'd4, OP_ADDI, 32'd10, 32'd0, 32'd5, 32'h20, 32'd15, 32'h24, 1'b0);
        tick();
        set_issue(4'd5, OP_ANDI, 32'hFF, 32'd0, 32'h0F, 32'h24, 32'h0F, 32'h28, 1'b0);
        tick(); check_state("full");
        rdy   = 1'b0;
        clear = 1'b1;
        set_issue(4'd6, OP_ORI, 32'h1, 32'd0, 32'h2, 32'h28, 32'h3, 32'h2C, 1'b0);
        tick(); check_state("clear");
        chk("clear.valid_low", 32'(bus.ex_cdb_valid), 32'd0);
        clear = 1'b0;
        rdy   = 1'b1;
        bus.if_issue_ex = 1'b0;
        tick(); check_state("post_clear");

        // rdy low freezes everything, even with grant and issue asserted
        set_issue(4'd7, OP_XORI, 32'hAAAA, 32'd0, 32'hFFFF, 32'h30, 32'h5555, 32'h34, 1'b0);
        tick(); check_state("stall_fill");
        rdy = 1'b0;
        bus.cdb_grant = 1'b1;
        set_issue(4'd8, OP_SUB, 32'd1, 32'd1, 32'd0, 32'h34, 32'd0, 32'h38, 1'b0);
        tick(); check_state("stall1");
        tick(); check_state("stall2");
        chk("stall.tag7", 32'(bus.ex_cdb_tag), 32'd7);
        rdy = 1'b1;
        bus.if_issue_ex = 1'b0;
        tick(); check_state("stall_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_alu.md
# ex_alu

Integer execution unit directly downstream of the reservation station. It accepts one fully-operand-ready RV32I ALU, branch or jump micro-op per cycle. It computes the result, next-PC target and taken flag, and holds them in a 2-entry result buffer until the common data bus (CDB) arbiter grants a broadcast slot. Back-pressure to the reservation station is a single idle flag.

## Interface
- TAG_W, 4, ROB tag width; must equal `tagWidth` in defines.v
- OP_W, 6, op-type width; must equal `opTypeWidth`
- DATA_W, 32, operand/result width (`dataWidth`); `immWidth`, `addrWidth` also 32
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low all state frozen
- clear  in  1  misprediction flush; synchronous, empties the buffer
- ex_idle  out  1  high when the buffer has a free slot this cycle
- if_issue_ex  in  1  reservation station dispatches a micro-op
- dest_ex  in  TAG_W  ROB tag of the micro-op
- op_type_to_ex  in  OP_W  operation code (defines.v encodings)
- data_rs1_to_ex, data_rs2_to_ex  in  32  source values (already resolved)
- imm_to_ex  in  32  sign-extended immediate
- pc_to_ex  in  32  instruction PC
- cdb_grant  in  1  arbiter accepts the current head this cycle
- ex_cdb_valid  out  1  head entry valid
- ex_cdb_tag  out  TAG_W  head ROB tag
- ex_cdb_data  out  32  head result value
- ex_cdb_target  out  32  head branch/jump target PC
- ex_cdb_taken  out  1  head redirects control flow

## Operation
- **ALU functions:**
  - ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA on rs1, rs2.
  - ADDI/ANDI/ORI/XORI/SLTI/SLTIU/SLLI/SRLI/SRAI on rs1, imm.
  - All arithmetic is mod 2^32. The shift amount is bits [4:0] of rs2 or imm only.
  - SRA/SRAI replicate bit 31.
  - SLT compares signed, SLTU unsigned.
- **LUI:** data = imm.
- **AUIPC:** data = pc + imm.
- **Non-branch ops:** taken = 0, target = pc + 4.
- **JAL:** data = pc + 4, target = pc + imm, taken = 1.
- **JALR:** data = pc + 4, target = (rs1 + imm) & ~1, taken = 1.
- **Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU):**
  - data = 0.
  - taken = comparison result.
  - target = pc + imm if taken, else pc + 4.
- **Unknown op_type:** data = 0, taken = 0, target = pc + 4. No error signalled.
- **Buffer:** 2-entry FIFO of {tag, data, target, taken}.
  - Count is 0..2.
  - ex_idle = (count < 2). It depends on registered count only; there is no combinational path from cdb_grant.
- **Push:** rdy & if_issue_ex & ex_idle. An issue while not idle is a protocol violation by the upstream stage and is ignored.
- **Pop:** rdy & ex_cdb_valid & cdb_grant.
- **Push and pop in the same cycle:** count unchanged, FIFO order preserved.
- **Head outputs:** ex_cdb_* always show the head entry. ex_cdb_valid = (count != 0).
- **rdy low:** no push, no pop, grant ignored, outputs held.
- **Reset and clear:**
  - rst or clear (rst has priority; clear acts even when rdy is low) sets count to 0.
  - A micro-op issued in the same cycle as clear is discarded.
  - Reset values: ex_cdb_valid 0, ex_cdb_tag 0, ex_cdb_data 0, ex_cdb_target 0, ex_cdb_taken 0, ex_idle 1.
  - Entry payloads are also zeroed on rst, so the outputs read 0.

## Timing
- Issue in cycle N with the buffer empty → ex_cdb_valid high in cycle N+1 with the computed payload. Latency is 1 cycle.
- Result is held until the cycle in which cdb_grant is high. The next entry, if any, appears in the following cycle.
- **Sustained throughput:** 1 op/cycle while cdb_grant stays high.
- **With grant low:**
  - Two ops fill the buffer.
  - ex_idle drops in the cycle after the second push.
- Head pops with grant in cycle M → ex_idle high in cycle M+1.
- clear in cycle N → ex_cdb_valid low and ex_idle high in cycle N+1.

## Structure
- **Shared in defines.v:**
  - op-type encodings for all ALU, branch and jump ops
  - tagWidth, opTypeWidth, dataWidth, immWidth, addrWidth
  - a `exBufSize` constant of 2
- **Sub-module:** `alu_core`, purely combinational. It maps {op, rs1, rs2, imm, pc} to {data, target, taken}.
- **ex_alu itself:** owns the FIFO pointers, count and the handshake logic.

## Test plan
- **Reset:** assert rst for 2 cycles with if_issue_ex high → ex_cdb_valid 0, ex_idle 1, all payload outputs 0.
- **Arithmetic/shift:**
  - SUB rs1=5, rs2=7, tag 3 → next cycle valid, tag 3, data 0xFFFFFFFE.
  - SRAI rs1=0x80000000, imm=0x21 → data 0xC0000000 (shamt 1).
- **Branch/jump:**
  - BLT pc=0x100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 → taken 1, target 0x120.
  - BLTU with the same operands → taken 0, target 0x104.
  - JALR rs1=0x203, imm=4 → target 0x206, data = pc + 4.
- **Back-pressure:**
  - grant held low, issue tags 1, 2, 3 on consecutive cycles → ex_idle low after the second; tag 3 is not accepted.
  - Raise grant → tags 1 then 2 broadcast on consecutive cycles, then ex_idle high.
- **Simultaneous push/pop:** count 1, grant high plus a new issue in the same cycle → head advances, count stays 1, no entry lost or duplicated.
- **Flush/stall:**
  - Buffer full, clear with rdy low → next cycle valid 0, idle 1.
  - Separately, rdy low with grant high → no pop, outputs unchanged.
